// File: rtl/avalon_regbank.sv
// Avalon-MM register bank with shadow/active copies, byte-enabled writes and bulk commit.
// Latency: writes land in shadow on the next edge, reads return one cycle after the strobe.
// Backpressure: none; read, write and commit are all accepted every cycle.
// Optional feature: define REGBANK_W1C_EN to turn the top register into a sticky W1C status register.
module avalon_regbank #(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 8,
  localparam int ADDR_W   = $clog2(NUM_REGS),
  localparam int NBYTES   = DATA_W / 8
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [ADDR_W-1:0]          address,
  input  logic                       write,
  input  logic [DATA_W-1:0]          writedata,
  input  logic [NBYTES-1:0]          byteenable,
  input  logic                       read,
  output logic [DATA_W-1:0]          readdata,
  output logic                       readdatavalid,
  input  logic                       commit,
  output logic                       pending,
  input  logic [DATA_W-1:0]          event_in,
  output logic [NUM_REGS*DATA_W-1:0] Q
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  logic [DATA_W-1:0] shadow_q [NUM_REGS];
  logic [DATA_W-1:0] shadow_d [NUM_REGS];
  logic [DATA_W-1:0] active_q [NUM_REGS];
  logic [DATA_W-1:0] active_d [NUM_REGS];
  logic [DATA_W-1:0] readdata_q;
  logic [DATA_W-1:0] readdata_d;
  logic              readdatavalid_q;
  logic              readdatavalid_d;
  logic              pending_q;
  logic              pending_d;
  logic              write_marks_pending;

`ifndef REGBANK_W1C_EN
  // Status inputs have no consumer when the sticky register is not built.
  logic unused_event_in;
  assign unused_event_in = ^event_in;
`endif

  // Next-state for register storage: byte-lane shadow write, then commit copies post-write shadow.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (write) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (byteenable[b]) begin
          shadow_d[address][8*b +: 8] = writedata[8*b +: 8];
        end
      end
    end
`ifdef REGBANK_W1C_EN
    // Sticky status: write-one-to-clear within enabled lanes, events set and win over clears.
    shadow_d[LAST] = shadow_q[LAST];
    if (write && (address == LAST)) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (byteenable[b]) begin
          shadow_d[LAST][8*b +: 8] = shadow_q[LAST][8*b +: 8] & ~writedata[8*b +: 8];
        end
      end
    end
    shadow_d[LAST] = shadow_d[LAST] | event_in;
`endif
    if (commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        active_d[i] = shadow_d[i];
      end
    end
`ifdef REGBANK_W1C_EN
    // Single-copy register: active tracks the one storage, commit has no extra effect.
    active_d[LAST] = shadow_d[LAST];
`endif
  end

  // Next-state for pending flag and read return path.
  always_comb begin
    write_marks_pending = write && (|byteenable);
`ifdef REGBANK_W1C_EN
    if (address == LAST) begin
      write_marks_pending = 1'b0;
    end
`endif
    pending_d = pending_q;
    if (write_marks_pending) begin
      pending_d = 1'b1;
    end
    // Commit clears pending even when a write lands in the same cycle, since it is committed too.
    if (commit) begin
      pending_d = 1'b0;
    end
    readdatavalid_d = read;
    readdata_d      = readdata_q;
    if (read) begin
      readdata_d = shadow_q[address];
    end
  end

  // State registers with synchronous active-low reset overriding all requests.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
      pending_q       <= 1'b0;
    end else begin
      shadow_q        <= shadow_d;
      active_q        <= active_d;
      readdata_q      <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
      pending_q       <= pending_d;
    end
  end

  // Flatten active registers onto Q.
  always_comb begin
    Q = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      Q[k*DATA_W +: DATA_W] = active_q[k];
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = readdatavalid_q;
  assign pending       = pending_q;

endmodule

// File: tb/tb_avalon_regbank.sv
// Directed self-checking bench for avalon_regbank (DATA_W=32, NUM_REGS=8).
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
// Covers reset, byte lanes, commit merge, read-during-write, reset with read in flight, top register.
module tb_avalon_regbank;

  logic         clock;
  logic         resetn;
  logic [2:0]   address;
  logic         write;
  logic [31:0]  writedata;
  logic [3:0]   byteenable;
  logic         read;
  logic [31:0]  readdata;
  logic         readdatavalid;
  logic         commit;
  logic         pending;
  logic [31:0]  event_in;
  logic [255:0] Q;

  int errors;
  int checks;

  avalon_regbank #(.DATA_W(32), .NUM_REGS(8)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .address       (address),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .read          (read),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .commit        (commit),
    .pending       (pending),
    .event_in      (event_in),
    .Q             (Q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    write      = 1'b0;
    read       = 1'b0;
    commit     = 1'b0;
    byteenable = 4'h0;
    writedata  = 32'h0;
    event_in   = 32'h0;
    address    = 3'd0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle();
    step();
    step();
    checks++;
    if (Q !== 256'h0) begin
      errors++;
      $display("FAIL reset_q: got %h expected 0", Q);
    end
    checks++;
    if (pending !== 1'b0 || readdatavalid !== 1'b0 || readdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outs: pending=%b rdv=%b rd=%h expected 0/0/0", pending, readdatavalid, readdata);
    end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_byteenable();
    address = 3'd2; write = 1'b1; writedata = 32'hAABBCCDD; byteenable = 4'b0101;
    step();
    idle();
    checks++;
    if (pending !== 1'b1) begin
      errors++;
      $display("FAIL be_pending_set: got %b expected 1", pending);
    end
    checks++;
    if (Q[2*32 +: 32] !== 32'h0) begin
      errors++;
      $display("FAIL be_q_before_commit: got %h expected 00000000", Q[2*32 +: 32]);
    end
    address = 3'd2; read = 1'b1;
    step();
    idle();
    checks++;
    if (readdatavalid !== 1'b1 || readdata !== 32'h00BB00DD) begin
      errors++;
      $display("FAIL be_shadow_read: rdv=%b rd=%h expected 1/00bb00dd", readdatavalid, readdata);
    end
    commit = 1'b1;
    step();
    idle();
    checks++;
    if (readdatavalid !== 1'b0 || readdata !== 32'h00BB00DD) begin
      errors++;
      $display("FAIL readdata_hold: rdv=%b rd=%h expected 0/00bb00dd", readdatavalid, readdata);
    end
    checks++;
    if (Q[2*32 +: 32] !== 32'h00BB00DD || pending !== 1'b0) begin
      errors++;
      $display("FAIL be_commit: q=%h pending=%b expected 00bb00dd/0", Q[2*32 +: 32], pending);
    end
  endtask

  task automatic test_write_commit();
    address = 3'd1; write = 1'b1; writedata = 32'h12345678; byteenable = 4'hF; commit = 1'b1;
    step();
    idle();
    checks++;
    if (Q[1*32 +: 32] !== 32'h12345678 || pending !== 1'b0) begin
      errors++;
      $display("FAIL write_commit: q=%h pending=%b expected 12345678/0", Q[1*32 +: 32], pending);
    end
    checks++;
    if (Q[2*32 +: 32] !== 32'h00BB00DD) begin
      errors++;
      $display("FAIL write_commit_other: q2=%h expected 00bb00dd", Q[2*32 +: 32]);
    end
  endtask

  task automatic test_zero_be();
    address = 3'd4; write = 1'b1; writedata = 32'hFFFFFFFF; byteenable = 4'h0;
    step();
    idle();
    checks++;
    if (pending !== 1'b0) begin
      errors++;
      $display("FAIL zero_be_pending: got %b expected 0", pending);
    end
    address = 3'd4; read = 1'b1;
    step();
    idle();
    checks++;
    if (readdatavalid !== 1'b1 || readdata !== 32'h0) begin
      errors++;
      $display("FAIL zero_be_read: rdv=%b rd=%h expected 1/00000000", readdatavalid, readdata);
    end
  endtask

  task automatic test_read_during_write();
    address = 3'd3; write = 1'b1; writedata = 32'h11111111; byteenable = 4'hF; commit = 1'b1;
    step();
    idle();
    address = 3'd3; read = 1'b1; write = 1'b1; writedata = 32'h22222222; byteenable = 4'hF;
    step();
    idle();
    checks++;
    if (readdatavalid !== 1'b1 || readdata !== 32'h11111111) begin
      errors++;
      $display("FAIL rdw_old: rdv=%b rd=%h expected 1/11111111", readdatavalid, readdata);
    end
    checks++;
    if (pending !== 1'b1) begin
      errors++;
      $display("FAIL rdw_pending: got %b expected 1", pending);
    end
    address = 3'd3; read = 1'b1;
    step();
    idle();
    checks++;
    if (readdatavalid !== 1'b1 || readdata !== 32'h22222222) begin
      errors++;
      $display("FAIL rdw_new: rdv=%b rd=%h expected 1/22222222", readdatavalid, readdata);
    end
  endtask

  task automatic test_reset_inflight();
    address = 3'd5; write = 1'b1; writedata = 32'hCAFEF00D; byteenable = 4'hF;
    step();
    idle();
    checks++;
    if (pending !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_pending: got %b expected 1", pending);
    end
    address = 3'd5; read = 1'b1; commit = 1'b1; resetn = 1'b0;
    step();
    idle();
    checks++;
    if (readdatavalid !== 1'b0 || pending !== 1'b0 || Q !== 256'h0 || readdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_inflight: rdv=%b pending=%b rd=%h q_nonzero=%b expected 0/0/0/0", readdatavalid, pending, readdata, |Q);
    end
    resetn = 1'b1;
    step();
    checks++;
    if (readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_pulse: rdv=%b expected 0", readdatavalid);
    end
    address = 3'd5; read = 1'b1;
    step();
    idle();
    checks++;
    if (readdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_shadow_cleared: rd=%h expected 00000000", readdata);
    end
  endtask

`ifdef REGBANK_W1C_EN
  task automatic test_top_register();
    event_in = 32'h5;
    step();
    idle();
    checks++;
    if (Q[7*32 +: 32] !== 32'h5 || pending !== 1'b0) begin
      errors++;
      $display("FAIL w1c_set: q7=%h pending=%b expected 5/0", Q[7*32 +: 32], pending);
    end
    address = 3'd7; write = 1'b1; writedata = 32'h1; byteenable = 4'hF; event_in = 32'h1;
    step();
    idle();
    checks++;
    if (Q[7*32 +: 32] !== 32'h5) begin
      errors++;
      $display("FAIL w1c_set_wins: q7=%h expected 5", Q[7*32 +: 32]);
    end
    address = 3'd7; write = 1'b1; writedata = 32'h4; byteenable = 4'hF;
    step();
    idle();
    checks++;
    if (Q[7*32 +: 32] !== 32'h1 || pending !== 1'b0) begin
      errors++;
      $display("FAIL w1c_clear: q7=%h pending=%b expected 1/0", Q[7*32 +: 32], pending);
    end
    address = 3'd7; write = 1'b1; writedata = 32'h1; byteenable = 4'h0;
    step();
    idle();
    checks++;
    if (Q[7*32 +: 32] !== 32'h1) begin
      errors++;
      $display("FAIL w1c_lane_masked: q7=%h expected 1", Q[7*32 +: 32]);
    end
  endtask
`else
  task automatic test_top_register();
    event_in = 32'hFFFF0005;
    step();
    idle();
    checks++;
    if (Q[7*32 +: 32] !== 32'h0 || pending !== 1'b0) begin
      errors++;
      $display("FAIL event_ignored: q7=%h pending=%b expected 0/0", Q[7*32 +: 32], pending);
    end
    address = 3'd7; write = 1'b1; writedata = 32'h0000A501; byteenable = 4'b0011; event_in = 32'h10;
    step();
    idle();
    checks++;
    if (pending !== 1'b1 || Q[7*32 +: 32] !== 32'h0) begin
      errors++;
      $display("FAIL top_write: pending=%b q7=%h expected 1/0", pending, Q[7*32 +: 32]);
    end
    commit = 1'b1;
    step();
    idle();
    checks++;
    if (Q[7*32 +: 32] !== 32'h0000A501 || pending !== 1'b0) begin
      errors++;
      $display("FAIL top_commit: q7=%h pending=%b expected 0000a501/0", Q[7*32 +: 32], pending);
    end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    resetn = 1'b0;
    idle();
    test_reset();
    test_byteenable();
    test_write_commit();
    test_zero_be();
    test_read_during_write();
    test_reset_inflight();
    test_top_register();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/avalon_regbank.md
AVALON_REGBANK -- requirements
Module: avalon_regbank

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter NUM_REGS, default 8, register count; SHALL be a power of two in the range 2..64.
REQ-003 Derived constants SHALL be ADDR_W = log2(NUM_REGS) and NBYTES = DATA_W/8.
REQ-004 Port clock, input, 1: rising-edge clock for all state.
REQ-005 Port resetn, input, 1: reset, synchronous, active-low.
REQ-006 Port address, input, ADDR_W: register index for the read or write in this cycle.
REQ-007 Port write, input, 1: write strobe.
REQ-008 Port writedata, input, DATA_W: write data.
REQ-009 Port byteenable, input, NBYTES: per-byte write enable; bit i covers writedata[8i+7:8i].
REQ-010 Port read, input, 1: read strobe.
REQ-011 Port readdata, output, DATA_W: read result.
REQ-012 Port readdatavalid, output, 1: one-cycle pulse marking readdata as valid.
REQ-013 Port commit, input, 1: copy all shadow registers to the active registers.
REQ-014 Port pending, output, 1: shadow contents have been written since the last commit.
REQ-015 Port event_in, input, DATA_W: sticky status set inputs; used only under REQ-031.
REQ-016 Port Q, output, NUM_REGS*DATA_W: active registers, flattened; register k occupies bits [k*DATA_W+DATA_W-1 : k*DATA_W].

Function
REQ-017 Each register SHALL have a shadow copy and an active copy; only active copies drive Q.
REQ-018 Write SHALL update the shadow[address] byte lanes whose byteenable bit is 1, at the next edge; all other lanes SHALL hold.
REQ-019 Commit SHALL copy every shadow register to its active register at the next edge.
REQ-020 Write and commit in the same cycle: the active register SHALL receive the merged post-write value; no cycle is lost.
REQ-021 Read SHALL return shadow[address] on readdata, with readdatavalid high, exactly one cycle after the read strobe.
REQ-022 readdata SHALL hold its last value when readdatavalid is low.
REQ-023 Read and write to the same address in the same cycle: readdata SHALL return the pre-write value.
REQ-024 Read and write asserted together are both serviced; no stall, no waitrequest.
REQ-025 pending SHALL set at the edge after any write whose byteenable is nonzero.
REQ-026 pending SHALL clear at the edge after commit, including when a write occurs in the same cycle.
REQ-027 A write with byteenable all zero SHALL change no state and SHALL NOT set pending.

Reset
REQ-028 While resetn is low at an edge, all shadow and active registers SHALL become 0, along with Q, readdata, readdatavalid and pending.
REQ-029 Reset SHALL override write, read and commit in the same cycle.
REQ-030 A read issued in the cycle before reset SHALL NOT produce a readdatavalid pulse after reset.

Configuration
REQ-031 With macro REGBANK_W1C_EN defined, register NUM_REGS-1 SHALL be a single-copy sticky status register:
- the shadow and active copies are the same storage, and Q reflects it immediately;
- a bit sets when the matching event_in bit is 1;
- a write clears each bit where writedata is 1 within an enabled byte;
- set wins over clear in the same cycle;
- commit does not affect this register;
- writes to this register do not set pending.
REQ-032 Without REGBANK_W1C_EN, register NUM_REGS-1 SHALL behave as an ordinary register and event_in SHALL be ignored.

Verification
REQ-033 Write addr 2, data 0xAABBCCDD, byteenable 0101, then commit -> reg 2 = 0x00BB00DD in Q, pending 1 then 0.
REQ-034 Write addr 1, data 0x12345678, byteenable 1111, with commit in the same cycle -> Q reg 1 = 0x12345678 next cycle; pending stays 0.
REQ-035 Reg 3 = 0x11111111; read and write addr 3, data 0x22222222 in the same cycle -> readdata 0x11111111 with readdatavalid one cycle later; a subsequent read returns 0x22222222.
REQ-036 resetn low while pending = 1 and a read is in flight -> all Q = 0, pending = 0, no readdatavalid pulse.
REQ-037 With REGBANK_W1C_EN: event_in = 0x5 for one cycle -> reg 7 = 0x5; write 0x1 while event_in = 0x1 -> reg 7 stays 0x5; write 0x4 -> reg 7 = 0x1.
